fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS core. It drives the PC register's next-PC input, issues one instruction-memory read per instruction, and holds the fetched instruction in the IF/ID register until decode accepts it. It also absorbs branch/jump redirects from EX, flushing the IF/ID register and discarding any in-flight memory response.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if.sv | 41 ++++
 rtl/fetch_ifid_reg.sv | 54 +++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: default widths, the PC
// increment, and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W    = 13;   // byte address, word aligned
    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;    // one instruction word in bytes

    typedef enum logic [2:0] {
        FETCH,   // issue the read for pc_i
        WAIT,    // request outstanding, waiting for the response
        FULL,    // IF/ID holds an instruction, waiting for decode
        DRAIN,   // request outstanding but its response will be thrown away
        FAULT    // misaligned redirect seen, no fetching
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Bundles the instruction-memory read port and the IF/ID handshake toward
// decode.
//   master : the fetch stage (drives requests and the IF/ID outputs)
//   slave  : the memory / decode side
// Signals:
//   imem_req_o    read request pulse          imem_addr_o  read address
//   imem_rvalid_i read response valid         imem_rdata_i read data
//   id_valid_o    IF/ID holds an instruction  id_ready_i   decode accepts
//   id_instr_o    fetched instruction         id_pc_o      its PC
//   id_pc4_o      its PC + 4
// -----------------------------------------------------------------------------
interface fetch_if #(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
);
    logic                imem_req_o;
    logic [PC_W-1:0]     imem_addr_o;
    logic                imem_rvalid_i;
    logic [INSTR_W-1:0]  imem_rdata_i;
    logic                id_valid_o;
    logic                id_ready_i;
    logic [INSTR_W-1:0]  id_instr_o;
    logic [PC_W-1:0]     id_pc_o;
    logic [PC_W-1:0]     id_pc4_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_rvalid_i, imem_rdata_i,
        output id_valid_o, id_instr_o, id_pc_o, id_pc4_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_rvalid_i, imem_rdata_i,
        input  id_valid_o, id_instr_o, id_pc_o, id_pc4_o,
        output id_ready_i
    );
endinterface

// File: rtl/fetch_ifid_reg.sv
// -----------------------------------------------------------------------------
// fetch_ifid_reg
// IF/ID holding register: instruction, its PC, PC+4 and a valid flag.
// Ports:
//   clk, reset  clock and synchronous active-high reset (clears everything)
//   i_load      capture i_instr/i_pc/i_pc4 and set valid
//   i_clear     drop valid (wins over i_load)
//   i_instr, i_pc, i_pc4   data to capture
//   o_valid, o_instr, o_pc, o_pc4   registered contents
// -----------------------------------------------------------------------------
module fetch_ifid_reg #(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [PC_W-1:0]    i_pc4,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic [PC_W-1:0]    o_pc4
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_pc4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
            r_pc4   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Computes the next PC for the external PC register
// (which loads every cycle), issues one instruction-memory read per
// instruction, holds the result in IF/ID until decode takes it, and absorbs
// EX redirects (flushing IF/ID and discarding any in-flight response).
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on redirect targets
// with bits [1:0] != 0 (sticky fault_o, FAULT state). Without it the target is
// forced to word alignment and fault_o stays 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pc_i                current PC from the PC register
//   pc_next_o           next PC (combinational)
//   redirect_valid_i    taken branch/jump pulse from EX
//   redirect_target_i   redirect destination
//   bus (fetch_if.master) imem read port and IF/ID handshake
//   fault_o             misaligned-redirect fault
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] pc_next_o,
    input  logic            redirect_valid_i,
    input  logic [PC_W-1:0] redirect_target_i,
    fetch_if.master         bus,
    output logic            fault_o
);
    import fetch_pkg::*;

    fetch_state_t    r_state;
    logic            r_fault;

    logic [PC_W-1:0] w_target;
    logic            w_misalign;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_load;
    logic            w_clear;

    logic               w_id_valid;
    logic [INSTR_W-1:0] w_id_instr;
    logic [PC_W-1:0]    w_id_pc;
    logic [PC_W-1:0]    w_id_pc4;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign = redirect_valid_i && (redirect_target_i[1:0] != 2'b00);
    assign w_target   = redirect_target_i;
`else
    assign w_misalign = 1'b0;
    // Low two bits are simply dropped so a bad target still lands on a word.
    assign w_target   = redirect_target_i & ~{{(PC_W-2){1'b0}}, 2'b11};
`endif

    // Wraps modulo 2^PC_W by construction of the width.
    assign w_pc_inc = pc_i + PC_W'(PC_INC);

    // Next PC, request strobe and IF/ID load/clear. A redirect overrides
    // everything the current state would otherwise do, including the FETCH
    // request: a request issued here would leave an untracked response.
    always_comb begin
        pc_next_o      = pc_i;
        bus.imem_req_o = 1'b0;
        w_load         = 1'b0;
        w_clear        = 1'b0;
        if (reset) begin
            pc_next_o = '0;
        end else if (redirect_valid_i) begin
            w_clear = 1'b1;
            if (!w_misalign) begin
                pc_next_o = w_target;
            end
        end else begin
            case (r_state)
                FETCH: bus.imem_req_o = 1'b1;
                WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        pc_next_o = w_pc_inc;
                        w_load    = 1'b1;
                    end
                end
                FULL: begin
                    if (bus.id_ready_i) begin
                        w_clear = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_addr_o = pc_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_fault <= 1'b0;
        end else if (redirect_valid_i) begin
            // A misaligned target sets the fault; an aligned one clears it.
            r_fault <= w_misalign;
            // A response still in flight must be drained before anything new
            // is requested; DRAIN decides FETCH vs FAULT from r_fault.
            if (r_state == DRAIN || (r_state == WAIT && !bus.imem_rvalid_i)) begin
                r_state <= DRAIN;
            end else if (w_misalign) begin
                r_state <= FAULT;
            end else begin
                r_state <= FETCH;
            end
        end else begin
            case (r_state)
                FETCH: r_state <= WAIT;
                WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (bus.id_ready_i) begin
                        r_state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.imem_rvalid_i) begin
                        r_state <= r_fault ? FAULT : FETCH;
                    end
                end
                FAULT: r_state <= FAULT;
                default: r_state <= FETCH;
            endcase
        end
    end

    assign fault_o = r_fault;

    fetch_ifid_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_ifid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_instr (bus.imem_rdata_i),
        .i_pc    (pc_i),
        .i_pc4   (w_pc_inc),
        .o_valid (w_id_valid),
        .o_instr (w_id_instr),
        .o_pc    (w_id_pc),
        .o_pc4   (w_id_pc4)
    );

    assign bus.id_valid_o = w_id_valid;
    assign bus.id_instr_o = w_id_instr;
    assign bus.id_pc_o    = w_id_pc;
    assign bus.id_pc4_o   = w_id_pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. The bench models the PC register (loads
// pc_next_o every edge) and an instruction memory that answers each request
// after `lat` cycles. Inputs change on the falling edge; outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PW = 13;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] pc_r;
    logic [PW-1:0] pc_next;
    logic          redirect_valid;
    logic [PW-1:0] redirect_target;
    logic          fault;

    int total = 0;
    int bad   = 0;

    int            lat;
    logic          pend;
    int            cnt;
    logic [PW-1:0] paddr;

    fetch_if #(.PC_W(PW), .INSTR_W(IW)) bus ();

    fetch_unit #(.PC_W(PW), .INSTR_W(IW)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_i              (pc_r),
        .pc_next_o         (pc_next),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .bus               (bus),
        .fault_o           (fault)
    );

    always #5 clk = ~clk;

    // PC register outside the fetch unit.
    always @(posedge clk) pc_r <= pc_next;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        if (a == 13'h0000) return 32'h2008_0005;
        return {8'hC0, 11'h000, a};
    endfunction

    // Memory responder: records a request seen in a cycle and raises rvalid
    // `lat` cycles later for exactly one cycle. Reset drops any pending read.
    initial begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        pend  = 1'b0;
        cnt   = 0;
        paddr = '0;
        forever begin
            @(negedge clk);
            bus.imem_rvalid_i = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = mem_word(paddr);
                    pend = 1'b0;
                end
            end
            #2;
            if (!reset && bus.imem_req_o) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = bus.imem_addr_o;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (pc_next !== 13'h0) begin bad++; $display("FAIL rst_pc_next: got %h want 0000", pc_next); end
            total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req_o); end
            total++; if (bus.id_valid_o !== 1'b0) begin bad++; $display("FAIL rst_id_valid: got %b want 0", bus.id_valid_o); end
            total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", fault); end
            total++; if ({bus.id_instr_o, bus.id_pc_o, bus.id_pc4_o} !== '0) begin bad++;
                $display("FAIL rst_ifid: got instr=%h pc=%h pc4=%h want all 0", bus.id_instr_o, bus.id_pc_o, bus.id_pc4_o); end
        end
        @(negedge clk); reset = 1'b0; #1;
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0000) begin bad++;
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0000", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_fetch();
        // WAIT with a 1-cycle memory: PC advances as the data is captured.
        @(negedge clk); #1;
        total++; if (pc_next !== 13'h0004) begin bad++; $display("FAIL fetch_pc_next: got %h want 0004", pc_next); end
        total++; if (bus.imem_req_o !== 1'b0 || bus.id_valid_o !== 1'b0) begin bad++;
            $display("FAIL fetch_wait: got req=%b id_valid=%b want 0 0", bus.imem_req_o, bus.id_valid_o); end
        @(negedge clk); #1;
        total++; if (bus.id_valid_o !== 1'b1 || bus.id_instr_o !== 32'h2008_0005) begin bad++;
            $display("FAIL fetch_instr: got valid=%b instr=%h want 1 20080005", bus.id_valid_o, bus.id_instr_o); end
        total++; if (bus.id_pc_o !== 13'h0000 || bus.id_pc4_o !== 13'h0004) begin bad++;
            $display("FAIL fetch_pc: got pc=%h pc4=%h want 0000 0004", bus.id_pc_o, bus.id_pc4_o); end
        @(negedge clk); #1;
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0004) begin bad++;
            $display("FAIL fetch_next_req: got req=%b addr=%h want 1 0004", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_stall();
        @(negedge clk); id_ready_drive(1'b0); #1;  // WAIT for 0x0004
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            total++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 13'h0004 || bus.id_pc4_o !== 13'h0008
                         || bus.id_instr_o !== mem_word(13'h0004)) begin bad++;
                $display("FAIL stall_hold: cyc=%0d got valid=%b pc=%h pc4=%h instr=%h", i, bus.id_valid_o,
                         bus.id_pc_o, bus.id_pc4_o, bus.id_instr_o); end
            total++; if (bus.imem_req_o !== 1'b0 || pc_r !== 13'h0008 || pc_next !== 13'h0008) begin bad++;
                $display("FAIL stall_pc: cyc=%0d got req=%b pc=%h pc_next=%h want 0 0008 0008", i,
                         bus.imem_req_o, pc_r, pc_next); end
        end
        @(negedge clk); id_ready_drive(1'b1); #1;
        total++; if (bus.imem_req_o !== 1'b0 || bus.id_valid_o !== 1'b1) begin bad++;
            $display("FAIL stall_release: got req=%b valid=%b want 0 1", bus.imem_req_o, bus.id_valid_o); end
        @(negedge clk); #1;
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0008 || bus.id_valid_o !== 1'b0) begin bad++;
            $display("FAIL stall_next_req: got req=%b addr=%h valid=%b want 1 0008 0", bus.imem_req_o,
                     bus.imem_addr_o, bus.id_valid_o); end
    endtask

    task automatic id_ready_drive(input logic v);
        bus.id_ready_i = v;
    endtask

    task automatic test_redirect_rvalid();
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 13'h0100; #1;  // WAIT, rvalid high
        total++; if (pc_next !== 13'h0100) begin bad++; $display("FAIL redir_rv_pc_next: got %h want 0100", pc_next); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        total++; if (bus.id_valid_o !== 1'b0) begin bad++; $display("FAIL redir_rv_valid: got %b want 0", bus.id_valid_o); end
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0100) begin bad++;
            $display("FAIL redir_rv_req: got req=%b addr=%h want 1 0100", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_drain();
        lat = 4;  // applies to the 0x0100 request issued this cycle
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 13'h0200; #1;
        total++; if (pc_next !== 13'h0200 || bus.imem_req_o !== 1'b0) begin bad++;
            $display("FAIL drain_redir: got pc_next=%h req=%b want 0200 0", pc_next, bus.imem_req_o); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        total++; if (bus.imem_req_o !== 1'b0 || bus.id_valid_o !== 1'b0 || pc_r !== 13'h0200) begin bad++;
            $display("FAIL drain_c1: got req=%b valid=%b pc=%h want 0 0 0200", bus.imem_req_o, bus.id_valid_o, pc_r); end
        @(negedge clk); #1;
        total++; if (bus.imem_req_o !== 1'b0) begin bad++; $display("FAIL drain_c2: got req=%b want 0", bus.imem_req_o); end
        @(negedge clk); #1;  // discarded response arrives
        total++; if (bus.imem_req_o !== 1'b0 || bus.id_valid_o !== 1'b0 || pc_next !== 13'h0200) begin bad++;
            $display("FAIL drain_rvalid: got req=%b valid=%b pc_next=%h want 0 0 0200", bus.imem_req_o,
                     bus.id_valid_o, pc_next); end
        @(negedge clk); #1;
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0200) begin bad++;
            $display("FAIL drain_req: got req=%b addr=%h want 1 0200", bus.imem_req_o, bus.imem_addr_o); end
        lat = 1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        total++; if (bus.id_valid_o !== 1'b1 || bus.id_instr_o !== mem_word(13'h0200)) begin bad++;
            $display("FAIL drain_after: got valid=%b instr=%h want 1 %h", bus.id_valid_o, bus.id_instr_o,
                     mem_word(13'h0200)); end
        @(negedge clk); #1;
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0204) begin bad++;
            $display("FAIL drain_after_req: got req=%b addr=%h want 1 0204", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_wrap();
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 13'h1FFC; #1;
        @(negedge clk); redirect_valid = 1'b0; #1;
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h1FFC) begin bad++;
            $display("FAIL wrap_req: got req=%b addr=%h want 1 1ffc", bus.imem_req_o, bus.imem_addr_o); end
        @(negedge clk); #1;
        total++; if (pc_next !== 13'h0000) begin bad++; $display("FAIL wrap_pc_next: got %h want 0000", pc_next); end
        @(negedge clk); #1;
        total++; if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 13'h1FFC || bus.id_pc4_o !== 13'h0000) begin bad++;
            $display("FAIL wrap_ifid: got valid=%b pc=%h pc4=%h want 1 1ffc 0000", bus.id_valid_o, bus.id_pc_o,
                     bus.id_pc4_o); end
        @(negedge clk); #1;
        total++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0000) begin bad++;
            $display("FAIL wrap_next_req: got req=%b addr=%h want 1 0000", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_misalign();
        @(negedge clk); redirect_valid = 1'b1; redirect_target = 13'h0102; #1;  // WAIT with rvalid
`ifdef FETCH_MISALIGN_TRAP_EN
        total++; if (pc_next !== 13'h0000) begin bad++; $display("FAIL mis_pc_next: got %h want 0000", pc_next); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        total++; if (fault !== 1'b1 || bus.id_valid_o !== 1'b0) begin bad++;
            $display("FAIL mis_fault: got fault=%b valid=%b want 1 0", fault, bus.id_valid_o); end
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.imem_req_o !== 1'b0 || fault !== 1'b1) begin bad++;
                $display("FAIL mis_hold: cyc=%0d got req=%b fault=%b want 0 1", i, bus.imem_req_o, fault); end
            @(negedge clk); #1;
        end
        redirect_valid = 1'b1; redirect_target = 13'h0040; #1;
        total++; if (pc_next !== 13'h0040) begin bad++; $display("FAIL mis_clear_pc: got %h want 0040", pc_next); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        total++; if (fault !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0040) begin bad++;
            $display("FAIL mis_clear: got fault=%b req=%b addr=%h want 0 1 0040", fault, bus.imem_req_o,
                     bus.imem_addr_o); end
`else
        total++; if (pc_next !== 13'h0100) begin bad++; $display("FAIL mis_pc_next: got %h want 0100", pc_next); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        total++; if (fault !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 13'h0100) begin bad++;
            $display("FAIL mis_req: got fault=%b req=%b addr=%h want 0 1 0100", fault, bus.imem_req_o,
                     bus.imem_addr_o); end
`endif
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        bus.id_ready_i  = 1'b1;
        lat             = 1;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_rvalid();
        test_drain();
        test_wrap();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
